// File: rtl/bram_pkg.sv
// Shared types for the byte-enabled true dual-port RAM: write-mode selector,
// clear-sequencer state and the per-lane read-data selection helper.
package bram_pkg;

   typedef enum logic [1:0] {
      READ_FIRST  = 2'd0,
      WRITE_FIRST = 2'd1,
      NO_CHANGE   = 2'd2
   } write_mode_t;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   // Next value of one byte of a port's read register for an enabled request.
   function automatic logic [7:0] rd_lane_sel(
      input write_mode_t mode,
      input logic        port_we,
      input logic        lane_we,
      input logic [7:0]  old_byte,
      input logic [7:0]  new_byte,
      input logic [7:0]  held_byte
   );
      logic [7:0] res;
      res = old_byte;
      case (mode)
         WRITE_FIRST: res = lane_we ? new_byte : old_byte;
         NO_CHANGE:   res = port_we ? held_byte : old_byte;
         default:     res = old_byte;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/bram_clear_seq.sv
// Post-reset zero-fill sequencer: sweeps every address once after reset
// release and flags busy while doing so.
module bram_clear_seq
   import bram_pkg::*;
#(
   parameter int unsigned ADDR_BITS    = 10,
   parameter bit          CLEAR_ON_RST = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   output logic                 busy_o,
   output logic [ADDR_BITS-1:0] clr_addr_o
);

   localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

   clr_state_t           state_reg, state_next;
   logic [ADDR_BITS-1:0] cnt_reg, cnt_next;
   logic                 pend_reg, pend_next;

   // pend_reg remembers that a sweep is owed for the reset just released.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         pend_reg  <= CLEAR_ON_RST;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         pend_reg  <= pend_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pend_next  = pend_reg;
      case (state_reg)
         IDLE: begin
            if (pend_reg) begin
               state_next = CLEAR;
               pend_next  = 1'b0;
            end
         end
         CLEAR: begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == LAST_ADDR) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy_o     = (state_reg == CLEAR);
   assign clr_addr_o = cnt_reg;

endmodule

// File: rtl/bram_dp_true_be.sv
// True dual-port RAM with per-byte write enables, selectable same-port write
// mode, optional output register and an automatic zero-fill after reset.
module bram_dp_true_be
   import bram_pkg::*;
#(
   parameter int unsigned RAM_WIDTH     = 8,
   parameter int unsigned RAM_ADDR_BITS = 10,
   parameter write_mode_t WRITE_MODE    = READ_FIRST,
   parameter bit          OUT_REG       = 1'b0,
   parameter bit          CLEAR_ON_RST  = 1'b1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     en_a_i,
   input  logic                     en_b_i,
   input  logic [RAM_WIDTH/8-1:0]   we_a_i,
   input  logic [RAM_WIDTH/8-1:0]   we_b_i,
   input  logic [RAM_ADDR_BITS-1:0] addr_a_i,
   input  logic [RAM_ADDR_BITS-1:0] addr_b_i,
   input  logic [RAM_WIDTH-1:0]     data_a_i,
   input  logic [RAM_WIDTH-1:0]     data_b_i,
   output logic [RAM_WIDTH-1:0]     data_a_o,
   output logic [RAM_WIDTH-1:0]     data_b_o,
   output logic                     collision_o,
   output logic                     busy_o
);

   localparam int unsigned NB    = RAM_WIDTH / 8;
   localparam int unsigned DEPTH = 2 ** RAM_ADDR_BITS;

   logic                     busy;
   logic [RAM_ADDR_BITS-1:0] clr_addr;
   logic                     req_a, req_b;
   logic                     collision_reg, collision_next;
   logic [RAM_WIDTH-1:0]     rd_a_word, rd_b_word;

   bram_clear_seq #(
      .ADDR_BITS    (RAM_ADDR_BITS),
      .CLEAR_ON_RST (CLEAR_ON_RST)
   ) u_clear_seq (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .busy_o     (busy),
      .clr_addr_o (clr_addr)
   );

   // User traffic is locked out while the sweep owns the array.
   assign req_a = en_a_i & ~busy & ~rst_i;
   assign req_b = en_b_i & ~busy & ~rst_i;

   assign collision_next = req_a & req_b & (addr_a_i == addr_b_i)
                           & ((|we_a_i) | (|we_b_i));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         collision_reg <= 1'b0;
      end else begin
         collision_reg <= collision_next;
      end
   end

   // One narrow array per byte lane; the A write is issued last so it wins
   // a lane that both ports hit in the same cycle.
   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_a_reg, rd_b_reg;
      logic [7:0] din_a, din_b;

      assign din_a = data_a_i[gi*8 +: 8];
      assign din_b = data_b_i[gi*8 +: 8];

      always_ff @(posedge clk_i) begin
         if (busy) begin
            mem[clr_addr] <= '0;
         end else begin
            if (req_b && we_b_i[gi]) mem[addr_b_i] <= din_b;
            if (req_a && we_a_i[gi]) mem[addr_a_i] <= din_a;
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            rd_a_reg <= '0;
            rd_b_reg <= '0;
         end else begin
            if (req_a) begin
               rd_a_reg <= rd_lane_sel(WRITE_MODE, |we_a_i, we_a_i[gi],
                                       mem[addr_a_i], din_a, rd_a_reg);
            end
            if (req_b) begin
               rd_b_reg <= rd_lane_sel(WRITE_MODE, |we_b_i, we_b_i[gi],
                                       mem[addr_b_i], din_b, rd_b_reg);
            end
         end
      end

      assign rd_a_word[gi*8 +: 8] = rd_a_reg;
      assign rd_b_word[gi*8 +: 8] = rd_b_reg;
   end

   if (OUT_REG) begin : g_oreg
      logic                 vld_a_reg, vld_b_reg;
      logic [RAM_WIDTH-1:0] out_a_reg, out_b_reg;

      // The output stage only advances behind a request, so idle ports hold.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            vld_a_reg <= 1'b0;
            vld_b_reg <= 1'b0;
            out_a_reg <= '0;
            out_b_reg <= '0;
         end else begin
            vld_a_reg <= req_a;
            vld_b_reg <= req_b;
            if (vld_a_reg) out_a_reg <= rd_a_word;
            if (vld_b_reg) out_b_reg <= rd_b_word;
         end
      end

      assign data_a_o = out_a_reg;
      assign data_b_o = out_b_reg;
   end else begin : g_noreg
      assign data_a_o = rd_a_word;
      assign data_b_o = rd_b_word;
   end

   assign collision_o = collision_reg;
   assign busy_o      = busy;

endmodule

// File: tb/tb_bram_dp_true_be.sv
// Directed bench: four RAM instances (read-first, write-first, no-change,
// read-first with output register) driven in lock-step with the same stimulus.
module tb_bram_dp_true_be;
   import bram_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_a, en_b;
   logic [1:0]  we_a, we_b;
   logic [3:0]  addr_a, addr_b;
   logic [15:0] din_a, din_b;

   logic [15:0] qa [4];
   logic [15:0] qb [4];
   logic        coll [4];
   logic        busy [4];

   int   vectors = 0;
   int   miscompares = 0;
   int   n;
   logic coll_seen;

   always #5 clk = ~clk;

   bram_dp_true_be #(.RAM_WIDTH(16), .RAM_ADDR_BITS(4), .WRITE_MODE(READ_FIRST),
                     .OUT_REG(1'b0), .CLEAR_ON_RST(1'b1)) u_rf (
      .clk_i(clk), .rst_i(rst), .en_a_i(en_a), .en_b_i(en_b), .we_a_i(we_a), .we_b_i(we_b),
      .addr_a_i(addr_a), .addr_b_i(addr_b), .data_a_i(din_a), .data_b_i(din_b),
      .data_a_o(qa[0]), .data_b_o(qb[0]), .collision_o(coll[0]), .busy_o(busy[0]));

   bram_dp_true_be #(.RAM_WIDTH(16), .RAM_ADDR_BITS(4), .WRITE_MODE(WRITE_FIRST),
                     .OUT_REG(1'b0), .CLEAR_ON_RST(1'b1)) u_wf (
      .clk_i(clk), .rst_i(rst), .en_a_i(en_a), .en_b_i(en_b), .we_a_i(we_a), .we_b_i(we_b),
      .addr_a_i(addr_a), .addr_b_i(addr_b), .data_a_i(din_a), .data_b_i(din_b),
      .data_a_o(qa[1]), .data_b_o(qb[1]), .collision_o(coll[1]), .busy_o(busy[1]));

   bram_dp_true_be #(.RAM_WIDTH(16), .RAM_ADDR_BITS(4), .WRITE_MODE(NO_CHANGE),
                     .OUT_REG(1'b0), .CLEAR_ON_RST(1'b1)) u_nc (
      .clk_i(clk), .rst_i(rst), .en_a_i(en_a), .en_b_i(en_b), .we_a_i(we_a), .we_b_i(we_b),
      .addr_a_i(addr_a), .addr_b_i(addr_b), .data_a_i(din_a), .data_b_i(din_b),
      .data_a_o(qa[2]), .data_b_o(qb[2]), .collision_o(coll[2]), .busy_o(busy[2]));

   bram_dp_true_be #(.RAM_WIDTH(16), .RAM_ADDR_BITS(4), .WRITE_MODE(READ_FIRST),
                     .OUT_REG(1'b1), .CLEAR_ON_RST(1'b1)) u_rfo (
      .clk_i(clk), .rst_i(rst), .en_a_i(en_a), .en_b_i(en_b), .we_a_i(we_a), .we_b_i(we_b),
      .addr_a_i(addr_a), .addr_b_i(addr_b), .data_a_i(din_a), .data_b_i(din_b),
      .data_a_o(qa[3]), .data_b_o(qb[3]), .collision_o(coll[3]), .busy_o(busy[3]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
      $display("  vec %0d %s: observed 0x%h", vectors, tag, obs);
   endtask

   task automatic idle();
      en_a = 1'b0; en_b = 1'b0; we_a = 2'b00; we_b = 2'b00;
   endtask

   task automatic wr_a(input logic [3:0] a, input logic [15:0] d, input logic [1:0] we);
      en_a = 1'b1; we_a = we; addr_a = a; din_a = d;
      tick();
      idle();
   endtask

   task automatic rd_a(input logic [3:0] a);
      en_a = 1'b1; we_a = 2'b00; addr_a = a;
      tick();
      idle();
   endtask

   task automatic rd_b(input logic [3:0] a);
      en_b = 1'b1; we_b = 2'b00; addr_b = a;
      tick();
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
      repeat (3) tick();
      check("rst_busy", {15'd0, busy[0]}, 16'h0000);
      check("rst_qa", qa[0], 16'h0000);
      check("rst_qb", qb[0], 16'h0000);
      check("rst_coll", {15'd0, coll[0]}, 16'h0000);

      // Initial sweep: busy for exactly 16 cycles, then all zero.
      rst = 1'b0;
      tick();
      n = 0;
      while (busy[0] && n < 40) begin
         n++;
         tick();
      end
      check("sweep_len", 16'(n), 16'd16);
      for (int i = 0; i < 16; i++) begin
         rd_a(4'(i));
         check($sformatf("clr0_addr%0d", i), qa[0], 16'h0000);
      end

      // Byte enables.
      wr_a(4'd3, 16'h1234, 2'b11);
      wr_a(4'd3, 16'hABCD, 2'b01);
      rd_a(4'd3);
      check("be_rd_a", qa[0], 16'h12CD);
      rd_b(4'd3);
      check("be_rd_b", qb[0], 16'h12CD);

      // Write-write collision, A wins the shared lane.
      en_a = 1'b1; we_a = 2'b11; addr_a = 4'd5; din_a = 16'h1111;
      en_b = 1'b1; we_b = 2'b10; addr_b = 4'd5; din_b = 16'h2222;
      tick();
      idle();
      check("ww_coll_pulse", {15'd0, coll[0]}, 16'h0001);
      tick();
      check("ww_coll_drop", {15'd0, coll[0]}, 16'h0000);
      rd_a(4'd5);
      check("ww_data", qa[0], 16'h1111);

      // Disjoint lanes on the same address merge.
      en_a = 1'b1; we_a = 2'b01; addr_a = 4'd6; din_a = 16'h0033;
      en_b = 1'b1; we_b = 2'b10; addr_b = 4'd6; din_b = 16'h4400;
      tick();
      idle();
      check("ww2_coll_pulse", {15'd0, coll[0]}, 16'h0001);
      rd_b(4'd6);
      check("ww2_data", qb[0], 16'h4433);

      // Read/write collision: B reads the pre-write word.
      en_a = 1'b1; we_a = 2'b11; addr_a = 4'd5; din_a = 16'h5555;
      en_b = 1'b1; we_b = 2'b00; addr_b = 4'd5;
      tick();
      idle();
      check("rw_b_old", qb[0], 16'h1111);
      check("rw_coll_pulse", {15'd0, coll[0]}, 16'h0001);
      rd_a(4'd5);
      check("rw_coll_drop", {15'd0, coll[0]}, 16'h0000);
      check("rw_a_new", qa[0], 16'h5555);

      // Same-port write modes.
      wr_a(4'd2, 16'h00AA, 2'b11);
      rd_a(4'd3);
      check("mode_prior_nc", qa[2], 16'h12CD);
      wr_a(4'd2, 16'h00BB, 2'b11);
      check("mode_read_first", qa[0], 16'h00AA);
      check("mode_write_first", qa[1], 16'h00BB);
      check("mode_no_change", qa[2], 16'h12CD);
      check("mode_rf_oreg_lag", qa[3], 16'h12CD);
      tick();
      check("mode_rf_hold", qa[0], 16'h00AA);
      check("mode_nc_hold", qa[2], 16'h12CD);
      check("mode_rf_oreg", qa[3], 16'h00AA);

      // Reset in the middle of a sweep.
      wr_a(4'd9, 16'h9999, 2'b11);
      wr_a(4'd15, 16'hF0F0, 2'b11);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("mid_busy_start", {15'd0, busy[0]}, 16'h0001);
      repeat (6) tick();
      check("mid_busy_c7", {15'd0, busy[0]}, 16'h0001);
      rst = 1'b1;
      tick();
      check("mid_busy_drop", {15'd0, busy[0]}, 16'h0000);
      check("mid_rst_qa", qa[0], 16'h0000);
      rst = 1'b0;
      tick();
      n = 0;
      coll_seen = 1'b0;
      while (busy[0] && n < 40) begin
         coll_seen = coll_seen | coll[0];
         if (n == 15) begin
            en_a = 1'b1; we_a = 2'b11; addr_a = 4'd3; din_a = 16'hDEAD;
            en_b = 1'b1; we_b = 2'b11; addr_b = 4'd3; din_b = 16'hBEEF;
         end
         n++;
         tick();
      end
      idle();
      coll_seen = coll_seen | coll[0];
      check("mid_sweep_len", 16'(n), 16'd16);
      check("mid_no_coll", {15'd0, coll_seen}, 16'h0000);
      check("mid_qa_held", qa[0], 16'h0000);
      check("mid_qb_held", qb[0], 16'h0000);
      for (int i = 0; i < 16; i++) begin
         rd_a(4'(i));
         check($sformatf("clr1_addr%0d", i), qa[0], 16'h0000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bram_dp_true_be.md
BRAM_DP_TRUE_BE -- requirements
Module: bram_dp_true_be

Interface
REQ-001 Parameter RAM_WIDTH, default 8; data width in bits; SHALL be a multiple of 8; NB = RAM_WIDTH/8 byte lanes.
REQ-002 Parameter RAM_ADDR_BITS, default 10; depth = 2**RAM_ADDR_BITS words.
REQ-003 Parameter WRITE_MODE, default READ_FIRST; same-port read behaviour on write: READ_FIRST, WRITE_FIRST or NO_CHANGE.
REQ-004 Parameter OUT_REG, default 0; 1 adds an output register stage per port.
REQ-005 Parameter CLEAR_ON_RST, default 1; 1 zero-fills the array after reset.
REQ-006 clk_i  in  1  single clock; all logic on the rising edge.
REQ-007 rst_i  in  1  reset; synchronous, active-high.
REQ-008 en_a_i / en_b_i  in  1  port enable.
REQ-009 we_a_i / we_b_i  in  NB  per-byte write enables.
REQ-010 addr_a_i / addr_b_i  in  RAM_ADDR_BITS  word address.
REQ-011 data_a_i / data_b_i  in  RAM_WIDTH  write data.
REQ-012 data_a_o / data_b_o  out  RAM_WIDTH  read data.
REQ-013 collision_o  out  1  one-cycle pulse flagging an address collision.
REQ-014 busy_o  out  1  high while a clear sweep is in progress.

Function
REQ-015 Each port SHALL, when enabled, write byte lane k of data_x_i to mem[addr_x_i] iff we_x_i[k]=1.
REQ-016 Read latency SHALL be 1 + OUT_REG cycles from an enabled request edge to valid data_x_o.
REQ-017 With en_x_i=0, data_x_o and the optional output register SHALL hold their value.
REQ-018 READ_FIRST: data_x_o SHALL be the word before the write. WRITE_FIRST: data_x_o SHALL be the merged word after the byte write. NO_CHANGE: data_x_o SHALL hold whenever any bit of we_x_i is set.
REQ-019 A collision SHALL be: both ports enabled, addr_a_i == addr_b_i, and at least one we bit set on either port.
REQ-020 A collision SHALL cause collision_o=1 on the following cycle, for exactly one cycle per colliding request.
REQ-021 Write-write collision: on byte lanes written by both ports, port A data SHALL win. Lanes written by only one port SHALL take that port's data.
REQ-022 Read/write collision: the reading port SHALL return the pre-write word.
REQ-023 The clear FSM SHALL have states IDLE and CLEAR.
REQ-024 The FSM SHALL go IDLE->CLEAR on the first cycle with rst_i=0 after reset, if CLEAR_ON_RST=1.
REQ-025 In CLEAR the FSM SHALL write 0 to one address per cycle, counting 0 to 2**RAM_ADDR_BITS-1. It SHALL return to IDLE after the last address; the counter wraps to 0.
REQ-026 busy_o SHALL be high for exactly 2**RAM_ADDR_BITS cycles during CLEAR.
REQ-027 While busy_o=1, user requests SHALL be ignored: no writes, data outputs held, no collision flagged.
REQ-028 With CLEAR_ON_RST=0, the FSM SHALL stay in IDLE and array contents SHALL be undefined after power-up.

Reset
REQ-029 rst_i=1 SHALL force data_a_o, data_b_o, the output registers, collision_o and busy_o to 0, the FSM to IDLE and the clear counter to 0.
REQ-030 rst_i asserted mid-clear SHALL abort the sweep; a full sweep from address 0 SHALL restart on release.
REQ-031 rst_i SHALL not alter array contents except through the subsequent clear.

Structure
REQ-032 Package bram_pkg SHALL hold the write_mode_t enum (READ_FIRST, WRITE_FIRST, NO_CHANGE) and the clear-FSM state typedef.
REQ-033 Sub-module bram_clear_seq SHALL hold the IDLE/CLEAR FSM, the address counter and busy_o.
REQ-034 The array, byte merge, collision logic and output registers SHALL live in the top module.

Verification (RAM_WIDTH=16, RAM_ADDR_BITS=4, CLEAR_ON_RST=1 unless stated)
REQ-035 Reset release: busy_o=1 for exactly 16 cycles, then reading all 16 addresses returns 0x0000.
REQ-036 Byte enables: A writes 0x1234 with we=2'b11, then 0xABCD with we=2'b01 to addr 3. A read of addr 3 returns 0x12CD.
REQ-037 Write-write collision: A writes 0x1111 with we=11 and B writes 0x2222 with we=10, both to addr 5. Then collision_o pulses once and addr 5 reads 0x1111.
REQ-038 Modes: with addr 2 = 0x00AA, write 0x00BB and read the same cycle. READ_FIRST outputs 0x00AA; WRITE_FIRST outputs 0x00BB; NO_CHANGE holds the prior output. With OUT_REG=1 each result appears one cycle later.
REQ-039 Reset mid-clear: assert rst_i at clear cycle 7 for 1 cycle. busy_o drops, then restarts for a full 16 cycles. Requests issued during busy_o=1 have no effect.
